// File: rtl/nwc_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nwc_mem_arb_pkg
// Description : Shared types for the banked coefficient-memory arbiter.
//               Holds the arbiter state encoding, the requester-id type, and
//               the request record (write, bn, ma, wdata) carried from the
//               selected requester into the command register.
//               The record fields are sized to the widest supported memory
//               ports; the arbiter rejects wider parameterisations at
//               elaboration.
// Revision    : 1.0  initial release
// ============================================================================
package nwc_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // 0 = host load/unload path, 1 = NTT butterfly engine
    typedef logic req_id_t;

    localparam int REQ_D_WIDTH  = 32;
    localparam int REQ_MA_WIDTH = 6;

    typedef struct packed {
        logic                    write;
        logic [REQ_D_WIDTH-1:0]  bn;
        logic [REQ_MA_WIDTH-1:0] ma;
        logic [REQ_D_WIDTH-1:0]  wdata;
    } mem_req_t;

    function automatic req_id_t other_id(input req_id_t id);
        return ~id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nwc_mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : nwc_mem_arb_grant
// Description : Round-robin grant FSM with bounded burst for two requesters.
//               The current owner keeps the port while it stays valid, unless
//               the other requester is waiting and the owner has already had
//               BURST_MAX consecutive grants. req_ready is one-hot or zero.
// Ports       : clk, rst (async, active-high)
//               req_valid[1:0]  in   request present per requester
//               req_ready[1:0]  out  grant for this cycle (combinational)
// Revision    : 1.0  initial release
// ============================================================================
module nwc_mem_arb_grant
    import nwc_mem_arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    localparam logic [1:0]       C_IDLE      = IDLE;
    localparam logic [1:0]       C_OWN0      = OWN0;
    localparam logic [1:0]       C_OWN1      = OWN1;
    localparam logic [CNT_W-1:0] C_BURST_MAX = CNT_W'(BURST_MAX);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_grant;
    req_id_t          w_gid;
    req_id_t          w_owner;
    req_id_t          w_other;

    assign w_owner = (r_state == C_OWN1);
    assign w_other = other_id(w_owner);

    always_comb begin
        w_grant = 1'b0;
        w_gid   = 1'b0;
        if (r_state == C_IDLE) begin
            if (req_valid[0] && req_valid[1]) begin
                w_grant = 1'b1;
                w_gid   = ~r_last;
            end else if (req_valid[0]) begin
                w_grant = 1'b1;
                w_gid   = 1'b0;
            end else if (req_valid[1]) begin
                w_grant = 1'b1;
                w_gid   = 1'b1;
            end
        end else begin
            // Owner continues unless the other side is waiting and the burst
            // allowance is used up.
            if (req_valid[w_owner] && (!req_valid[w_other] || (r_cnt < C_BURST_MAX))) begin
                w_grant = 1'b1;
                w_gid   = w_owner;
            end else if (req_valid[w_other]) begin
                w_grant = 1'b1;
                w_gid   = w_other;
            end
        end
    end

    always_comb begin
        w_state_nxt = C_IDLE;
        w_cnt_nxt   = '0;
        if (w_grant) begin
            w_state_nxt = w_gid ? C_OWN1 : C_OWN0;
            if ((r_state != C_IDLE) && (w_gid == w_owner)) begin
                w_cnt_nxt = (r_cnt >= C_BURST_MAX) ? C_BURST_MAX : r_cnt + 1'b1;
            end else begin
                w_cnt_nxt = CNT_W'(1);
            end
        end
    end

    assign req_ready = w_grant ? (w_gid ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant) begin
                r_last <= w_gid;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nwc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nwc_mem_arbiter
// Description : Two-requester arbiter/sequencer for the banked coefficient
//               memory (BN banks x MA words). Requester 0 = host, 1 = NTT
//               engine. An accepted request becomes a registered memory
//               command one cycle later; reads return tagged data two cycles
//               after acceptance.
// Ports       : clk, rst (async, active-high)
//               req_valid/req_ready/req_write/req_bn/req_ma/req_wdata [1:0]
//               mem_r_enable, mem_w_enable, mem_bn_idx, mem_ma_idx,
//               mem_data_in (registered command), mem_ans (read data in)
//               rsp_valid[1:0], rsp_data, err_range (sticky)
// Config      : MEM_ARB_RANGE_CHECK_EN - suppress memory enables for
//               out-of-range indices, return zero read data, raise err_range.
// Revision    : 1.0  initial release
// ============================================================================
module nwc_mem_arbiter
    import nwc_mem_arb_pkg::*;
#(
    parameter int D_WIDTH   = 32,
    parameter int BN        = 4,
    parameter int MA        = 64,
    parameter int MA_WIDTH  = 6,
    parameter int BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [1:0]               req_write,
    input  logic [1:0][D_WIDTH-1:0]  req_bn,
    input  logic [1:0][MA_WIDTH-1:0] req_ma,
    input  logic [1:0][D_WIDTH-1:0]  req_wdata,
    output logic                     mem_r_enable,
    output logic                     mem_w_enable,
    output logic [D_WIDTH-1:0]       mem_bn_idx,
    output logic [MA_WIDTH-1:0]      mem_ma_idx,
    output logic [D_WIDTH-1:0]       mem_data_in,
    input  logic [D_WIDTH-1:0]       mem_ans,
    output logic [1:0]               rsp_valid,
    output logic [D_WIDTH-1:0]       rsp_data,
    output logic                     err_range
);

    if ((BURST_MAX < 1) || (BN < 1) || (MA < 1) || (MA > (1 << MA_WIDTH)) ||
        (D_WIDTH > REQ_D_WIDTH) || (MA_WIDTH > REQ_MA_WIDTH)) begin : g_bad_params
        $error("nwc_mem_arbiter: illegal parameter combination");
    end

    logic     w_accept;
    req_id_t  w_id;
    mem_req_t w_sel;
    logic     w_range_bad;

    nwc_mem_arb_grant #(
        .BURST_MAX (BURST_MAX)
    ) u_grant (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready)
    );

    // req_ready is one-hot, so bit 1 alone identifies the winner.
    assign w_accept = |(req_valid & req_ready);
    assign w_id     = req_ready[1];

    always_comb begin
        w_sel.write = req_write[w_id];
        w_sel.bn    = REQ_D_WIDTH'(req_bn[w_id]);
        w_sel.ma    = REQ_MA_WIDTH'(req_ma[w_id]);
        w_sel.wdata = REQ_D_WIDTH'(req_wdata[w_id]);
    end

`ifdef MEM_ARB_RANGE_CHECK_EN
    assign w_range_bad = (w_sel.bn >= REQ_D_WIDTH'(BN)) ||
                         ({1'b0, w_sel.ma} >= (REQ_MA_WIDTH + 1)'(MA));
`else
    assign w_range_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Command register: enables pulse for one cycle per accepted request;
    // address/data hold between commands.
    // ------------------------------------------------------------------
    logic                r_mem_r_enable;
    logic                r_mem_w_enable;
    logic [D_WIDTH-1:0]  r_mem_bn_idx;
    logic [MA_WIDTH-1:0] r_mem_ma_idx;
    logic [D_WIDTH-1:0]  r_mem_data_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_r_enable <= 1'b0;
            r_mem_w_enable <= 1'b0;
            r_mem_bn_idx   <= '0;
            r_mem_ma_idx   <= '0;
            r_mem_data_in  <= '0;
        end else begin
            r_mem_r_enable <= w_accept && !w_sel.write && !w_range_bad;
            r_mem_w_enable <= w_accept &&  w_sel.write && !w_range_bad;
            if (w_accept) begin
                r_mem_bn_idx  <= D_WIDTH'(w_sel.bn);
                r_mem_ma_idx  <= MA_WIDTH'(w_sel.ma);
                r_mem_data_in <= D_WIDTH'(w_sel.wdata);
            end
        end
    end

    assign mem_r_enable = r_mem_r_enable;
    assign mem_w_enable = r_mem_w_enable;
    assign mem_bn_idx   = r_mem_bn_idx;
    assign mem_ma_idx   = r_mem_ma_idx;
    assign mem_data_in  = r_mem_data_in;

    // ------------------------------------------------------------------
    // Response tag pipe. Stage 2 lines up with mem_ans. The "bad" bit marks
    // suppressed out-of-range reads so they return zero instead of stale
    // memory output.
    // ------------------------------------------------------------------
    logic    r_tag1_valid;
    req_id_t r_tag1_id;
    logic    r_tag1_bad;
    logic    r_tag2_valid;
    req_id_t r_tag2_id;
    logic    r_tag2_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag1_valid <= 1'b0;
            r_tag1_id    <= 1'b0;
            r_tag1_bad   <= 1'b0;
            r_tag2_valid <= 1'b0;
            r_tag2_id    <= 1'b0;
            r_tag2_bad   <= 1'b0;
        end else begin
            r_tag1_valid <= w_accept && !w_sel.write;
            r_tag1_id    <= w_id;
            r_tag1_bad   <= w_range_bad;
            r_tag2_valid <= r_tag1_valid;
            r_tag2_id    <= r_tag1_id;
            r_tag2_bad   <= r_tag1_bad;
        end
    end

    assign rsp_valid = {r_tag2_valid &&  r_tag2_id,
                        r_tag2_valid && !r_tag2_id};
    assign rsp_data  = (r_tag2_valid && !r_tag2_bad) ? mem_ans : '0;

`ifdef MEM_ARB_RANGE_CHECK_EN
    logic r_err_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_range <= 1'b0;
        end else if (w_accept && w_range_bad) begin
            r_err_range <= 1'b1;
        end
    end

    assign err_range = r_err_range;
`else
    assign err_range = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nwc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nwc_mem_arbiter
// Description : Directed bench for nwc_mem_arbiter. A behavioural memory sits
//               on the mem_* port; a reference copy of its contents predicts
//               read data, and expected responses wait in a scoreboard queue
//               until the DUT returns them.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nwc_mem_arbiter;

    localparam int D_WIDTH   = 32;
    localparam int BN        = 4;
    localparam int MA        = 64;
    localparam int MA_WIDTH  = 6;
    localparam int BURST_MAX = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [1:0]               req_write;
    logic [1:0][D_WIDTH-1:0]  req_bn;
    logic [1:0][MA_WIDTH-1:0] req_ma;
    logic [1:0][D_WIDTH-1:0]  req_wdata;
    logic                     mem_r_enable;
    logic                     mem_w_enable;
    logic [D_WIDTH-1:0]       mem_bn_idx;
    logic [MA_WIDTH-1:0]      mem_ma_idx;
    logic [D_WIDTH-1:0]       mem_data_in;
    logic [D_WIDTH-1:0]       mem_ans;
    logic [1:0]               rsp_valid;
    logic [D_WIDTH-1:0]       rsp_data;
    logic                     err_range;

    always #5 clk = ~clk;

    nwc_mem_arbiter #(
        .D_WIDTH   (D_WIDTH),
        .BN        (BN),
        .MA        (MA),
        .MA_WIDTH  (MA_WIDTH),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_bn       (req_bn),
        .req_ma       (req_ma),
        .req_wdata    (req_wdata),
        .mem_r_enable (mem_r_enable),
        .mem_w_enable (mem_w_enable),
        .mem_bn_idx   (mem_bn_idx),
        .mem_ma_idx   (mem_ma_idx),
        .mem_data_in  (mem_data_in),
        .mem_ans      (mem_ans),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .err_range    (err_range)
    );

    // Behavioural memory: read data valid one cycle after mem_r_enable.
    logic [D_WIDTH-1:0] mem     [0:BN-1][0:MA-1];
    logic [D_WIDTH-1:0] ref_mem [0:BN-1][0:MA-1];

    always @(posedge clk) begin
        if (mem_r_enable) mem_ans <= mem[mem_bn_idx[1:0]][mem_ma_idx];
        if (mem_w_enable) mem[mem_bn_idx[1:0]][mem_ma_idx] = mem_data_in;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic               id;
        logic [D_WIDTH-1:0] data;
        int                 due;
    } exp_t;
    exp_t sb[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [D_WIDTH-1:0] bn, input logic [MA_WIDTH-1:0] ma,
                           input logic [D_WIDTH-1:0] wd);
        req_valid[i] = v;
        req_write[i] = w;
        req_bn[i]    = bn;
        req_ma[i]    = ma;
        req_wdata[i] = wd;
    endtask

    // One cycle: check the grant, update the reference on expected
    // acceptance, then return #1 after the clock edge that accepts it.
    task automatic step(input logic [1:0] exp_ready, input string tag);
        logic  id;
        logic  ok;
        exp_t  e;
        @(negedge clk);
        chk(tag, 128'(req_ready), 128'(exp_ready));
        if (exp_ready != 2'b00) begin
            id = exp_ready[1];
            ok = (req_bn[id] < BN) && (32'(req_ma[id]) < MA);
            if (req_write[id]) begin
                if (ok) ref_mem[req_bn[id][1:0]][req_ma[id]] = req_wdata[id];
            end else begin
                e.id   = id;
                e.data = ok ? ref_mem[req_bn[id][1:0]][req_ma[id]] : '0;
                e.due  = cyc + 2;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, "idle_ready");
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_mem_en"},  128'({mem_r_enable, mem_w_enable}), 128'(0));
        chk({t, "_mem_idx"}, 128'({mem_bn_idx, mem_ma_idx}), 128'(0));
        chk({t, "_mem_dat"}, 128'(mem_data_in), 128'(0));
        chk({t, "_rsp"},     128'({rsp_valid, rsp_data, err_range}), 128'(0));
    endtask

    task automatic chk_cmd(input string t, input logic [1:0] wr_rd,
                           input logic [D_WIDTH-1:0] bn, input logic [MA_WIDTH-1:0] ma);
        chk({t, "_en"},  128'({mem_w_enable, mem_r_enable}), 128'(wr_rd));
        chk({t, "_idx"}, 128'({mem_bn_idx, mem_ma_idx}), 128'({bn, ma}));
    endtask

    // Response monitor: pops the scoreboard when rsp_valid appears and
    // flags responses that are unexpected or overdue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (rsp_valid !== 2'b00) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_valid", 128'(rsp_valid), 128'(e.id ? 2'b10 : 2'b01));
                    chk("rsp_data",  128'(rsp_data),  128'(e.data));
                    chk("rsp_cycle", 128'(cyc),       128'(e.due));
                end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk("rsp_missing", 128'(0), 128'(1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [9];
        for (int b = 0; b < BN; b++)
            for (int m = 0; m < MA; m++) begin
                mem[b][m]     = 32'hC0DE_0000 | 32'(b << 8) | 32'(m);
                ref_mem[b][m] = 32'hC0DE_0000 | 32'(b << 8) | 32'(m);
            end
        req_valid = '0; req_write = '0; req_bn = '0; req_ma = '0; req_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        chk("reset_ready", 128'(req_ready), 128'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Host write then read of bn=2, ma=10
        set_req(0, 1'b1, 1'b1, 32'd2, 6'd10, 32'h0000_00A5);
        step(2'b01, "t1_wr_grant");
        chk_cmd("t1_wr_cmd", 2'b10, 32'd2, 6'd10);
        chk("t1_wr_data", 128'(mem_data_in), 128'(32'hA5));
        set_req(0, 1'b1, 1'b0, 32'd2, 6'd10, 32'h0);
        step(2'b01, "t1_rd_grant");
        chk_cmd("t1_rd_cmd", 2'b01, 32'd2, 6'd10);
        set_req(0, 1'b0, 1'b0, 32'd0, 6'd0, 32'h0);
        idle(1);
        chk("t1_hold_idx", 128'({mem_w_enable, mem_r_enable, mem_bn_idx, mem_ma_idx}),
            128'({2'b00, 32'd2, 6'd10}));
        idle(3);

        // Both valid from the first cycle after reset
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst2");
        @(posedge clk); #1 rst = 1'b0;
        seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        for (int k = 0; k < 9; k++) begin
            set_req(0, 1'b1, 1'b0, 32'd0, 6'(k), 32'h0);
            set_req(1, 1'b1, 1'b0, 32'd3, 6'(20 + k), 32'h0);
            step(seq[k], $sformatf("t2_grant%0d", k));
        end
        set_req(0, 1'b0, 1'b0, 32'd0, 6'd0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'd0, 6'd0, 32'h0);
        idle(4);

        // Engine streams alone for 10 beats, host joins on beat 11
        for (int k = 0; k < 10; k++) begin
            set_req(1, 1'b1, 1'b0, 32'd1, 6'(40 + k), 32'h0);
            step(2'b10, $sformatf("t3_eng%0d", k));
        end
        set_req(0, 1'b1, 1'b0, 32'd2, 6'd10, 32'h0);
        step(2'b01, "t3_host_join");
        set_req(0, 1'b0, 1'b0, 32'd0, 6'd0, 32'h0);
        step(2'b10, "t3_eng_resume");
        set_req(1, 1'b0, 1'b0, 32'd0, 6'd0, 32'h0);
        idle(4);

        // Engine back-to-back write then read of bn=1, ma=5
        set_req(1, 1'b1, 1'b1, 32'd1, 6'd5, 32'h0000_1234);
        step(2'b10, "t4_wr_grant");
        chk_cmd("t4_wr_cmd", 2'b10, 32'd1, 6'd5);
        set_req(1, 1'b1, 1'b0, 32'd1, 6'd5, 32'h0);
        step(2'b10, "t4_rd_grant");
        chk_cmd("t4_rd_cmd", 2'b01, 32'd1, 6'd5);
        set_req(1, 1'b0, 1'b0, 32'd0, 6'd0, 32'h0);
        idle(4);

        // Reset the cycle after a read is accepted: response must vanish
        set_req(1, 1'b1, 1'b0, 32'd3, 6'd3, 32'h0);
        step(2'b10, "t5_rd_grant");
        rst = 1'b1;
        set_req(1, 1'b0, 1'b0, 32'd0, 6'd0, 32'h0);
        sb.delete();
        @(negedge clk);
        chk_zero("t5_rst_a");
        @(negedge clk);
        chk_zero("t5_rst_b");
        @(posedge clk); #1 rst = 1'b0;
        idle(5);

`ifdef MEM_ARB_RANGE_CHECK_EN
        // Out-of-range host read: no enable, zero data, sticky error
        set_req(0, 1'b1, 1'b0, 32'd4, 6'd3, 32'h0);
        step(2'b01, "t6_oor_grant");
        chk("t6_oor_en",  128'({mem_w_enable, mem_r_enable}), 128'(0));
        chk("t6_err_set", 128'(err_range), 128'(1));
        set_req(0, 1'b0, 1'b0, 32'd0, 6'd0, 32'h0);
        idle(3);
        chk("t6_err_sticky", 128'(err_range), 128'(1));
        set_req(0, 1'b1, 1'b1, 32'd0, 6'd2, 32'h0000_0077);
        step(2'b01, "t6_ok_grant");
        chk_cmd("t6_ok_cmd", 2'b10, 32'd0, 6'd2);
        chk("t6_err_hold", 128'(err_range), 128'(1));
        set_req(0, 1'b0, 1'b0, 32'd0, 6'd0, 32'h0);
        idle(3);
`else
        chk("err_range_tied", 128'(err_range), 128'(0));
`endif

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_drain", 128'(sb.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
